sta_job_ctrl: RTL and testbench

Job controller in front of the STA core. Accepts one graph job (node delays plus edge list) from a host over a valid/ready stream, buffers it, replays it to the core as one gap-free `in_valid` burst, captures the core's uncompressed `out_valid` result burst (worst delay plus path nodes) and returns it to the host through a second valid/ready stream. Sits between the host interface logic and the STA core inside the chip shell.

---
 rtl/sta_job_ctrl_if.sv | 44 ++++
 rtl/sta_job_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_sta_job_ctrl.sv | 488 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sta_job_ctrl_if.sv
// sta_job_ctrl_if: bundles the host job stream, the STA core port and the
// host result stream of the job controller. The controller uses the slave
// modport; the environment (host logic plus core) uses the master modport.
interface sta_job_ctrl_if;
   logic       h_valid;
   logic       h_ready;
   logic [3:0] h_delay;
   logic [3:0] h_source;
   logic [3:0] h_destination;

   logic       c_in_valid;
   logic [3:0] c_delay;
   logic [3:0] c_source;
   logic [3:0] c_destination;
   logic       c_out_valid;
   logic [7:0] c_worst_delay;
   logic [3:0] c_path;

   logic       r_valid;
   logic       r_ready;
   logic [7:0] r_worst_delay;
   logic [3:0] r_path;
   logic       r_last;
   logic       r_err;
   logic       busy;

   modport slave (
      input  h_valid, h_delay, h_source, h_destination,
      input  c_out_valid, c_worst_delay, c_path,
      input  r_ready,
      output h_ready,
      output c_in_valid, c_delay, c_source, c_destination,
      output r_valid, r_worst_delay, r_path, r_last, r_err, busy
   );

   modport master (
      output h_valid, h_delay, h_source, h_destination,
      output c_out_valid, c_worst_delay, c_path,
      output r_ready,
      input  h_ready,
      input  c_in_valid, c_delay, c_source, c_destination,
      input  r_valid, r_worst_delay, r_path, r_last, r_err, busy
   );
endinterface

// File: rtl/sta_job_ctrl.sv
// sta_job_ctrl: buffers one graph job from the host, replays it to the STA
// core as a single gap-free burst, captures the core's result burst and
// drains it back to the host. Optional WAIT timeout: define STA_TIMEOUT_EN.
module sta_job_ctrl #(
   parameter int JOB_LEN   = 32,
   parameter int DELAY_LEN = 16,
   parameter int MAX_PATH  = 16,
   parameter int TIMEOUT   = 1023
) (
   input logic clk,
   input logic rst_n,
   sta_job_ctrl_if.slave bus
);
   localparam int AW  = $clog2(JOB_LEN);
   localparam int CW  = AW + 1;
   localparam int DAW = $clog2(DELAY_LEN);
   localparam int PAW = $clog2(MAX_PATH);
   localparam int PW  = PAW + 1;
   localparam logic [CW-1:0] JOB_LEN_C   = CW'(JOB_LEN);
   localparam logic [CW-1:0] DELAY_CNT_C = CW'(DELAY_LEN);
   localparam logic [AW-1:0] DELAY_IDX_C = AW'(DELAY_LEN);
   localparam logic [PW-1:0] MAX_PATH_C  = PW'(MAX_PATH);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, COLLECT, DRAIN} state_t;

   state_t          state_q;
   logic [CW-1:0]   wcnt_q, rcnt_q;
   logic [PW-1:0]   pcnt_q, plen_q, dcnt_q;
   logic [3:0]      dlyMem  [DELAY_LEN];
   logic [3:0]      srcMem  [JOB_LEN];
   logic [3:0]      dstMem  [JOB_LEN];
   logic [3:0]      pathMem [MAX_PATH];

   logic            cInValid_q;
   logic [3:0]      cDelay_q, cSource_q, cDest_q;
   logic            rValid_q, rLast_q;
   logic [7:0]      rWorst_q;
   logic [3:0]      rPath_q;

   logic            hReady, hAccept;
   logic [AW-1:0]   issueIdx;
   logic [3:0]      issueDelay;
   logic            pathWe;
   logic [PAW-1:0]  pathIdx;
   logic [PW-1:0]   dcnt_d;

`ifdef STA_TIMEOUT_EN
   localparam logic [9:0] TIMEOUT_LAST_C = 10'(TIMEOUT - 1);
   logic [9:0]      tcnt_q;
   logic            rErr_q;
   assign bus.r_err = rErr_q;
`else
   assign bus.r_err = 1'b0;
`endif

   assign hReady  = rst_n && (wcnt_q < JOB_LEN_C) && (state_q != ISSUE);
   assign hAccept = bus.h_valid && hReady;
   assign dcnt_d  = dcnt_q + 1'b1;

   assign bus.h_ready       = hReady;
   assign bus.c_in_valid    = cInValid_q;
   assign bus.c_delay       = cDelay_q;
   assign bus.c_source      = cSource_q;
   assign bus.c_destination = cDest_q;
   assign bus.r_valid       = rValid_q;
   assign bus.r_worst_delay = rWorst_q;
   assign bus.r_path        = rPath_q;
   assign bus.r_last        = rLast_q;
   assign bus.busy          = (state_q != IDLE);

   // Pick the buffered beat to launch next; beats past the delay region carry no delay
   always_comb begin
      issueIdx   = (state_q == ISSUE) ? rcnt_q[AW-1:0] : '0;
      issueDelay = '0;
      if (issueIdx < DELAY_IDX_C)
         issueDelay = dlyMem[issueIdx[DAW-1:0]];
   end

   // Decide whether this cycle's core result beat lands in the path buffer
   always_comb begin
      pathWe  = 1'b0;
      pathIdx = '0;
      if (bus.c_out_valid) begin
         if (state_q == WAIT) begin
            pathWe = 1'b1;
         end else if (state_q == COLLECT && pcnt_q < MAX_PATH_C) begin
            pathWe  = 1'b1;
            pathIdx = pcnt_q[PAW-1:0];
         end
      end
   end

   // Job and path storage; contents are don't-care until their counters cover them
   always_ff @(posedge clk) begin
      if (hAccept) begin
         srcMem[wcnt_q[AW-1:0]] <= bus.h_source;
         dstMem[wcnt_q[AW-1:0]] <= bus.h_destination;
         if (wcnt_q < DELAY_CNT_C)
            dlyMem[wcnt_q[DAW-1:0]] <= bus.h_delay;
      end
      if (pathWe)
         pathMem[pathIdx] <= bus.c_path;
   end

   // Main controller: fill counting, burst replay, result capture and drain
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         wcnt_q     <= '0;
         rcnt_q     <= '0;
         pcnt_q     <= '0;
         plen_q     <= '0;
         dcnt_q     <= '0;
         cInValid_q <= 1'b0;
         cDelay_q   <= '0;
         cSource_q  <= '0;
         cDest_q    <= '0;
         rValid_q   <= 1'b0;
         rLast_q    <= 1'b0;
         rWorst_q   <= '0;
         rPath_q    <= '0;
`ifdef STA_TIMEOUT_EN
         tcnt_q     <= '0;
         rErr_q     <= 1'b0;
`endif
      end else begin
         if (hAccept)
            wcnt_q <= wcnt_q + 1'b1;
         case (state_q)
            IDLE: begin
               if (wcnt_q == JOB_LEN_C) begin
                  state_q    <= ISSUE;
                  cInValid_q <= 1'b1;
                  cDelay_q   <= issueDelay;
                  cSource_q  <= srcMem[issueIdx];
                  cDest_q    <= dstMem[issueIdx];
                  rcnt_q     <= CW'(1);
`ifdef STA_TIMEOUT_EN
                  rErr_q     <= 1'b0;
`endif
               end
            end
            ISSUE: begin
               if (rcnt_q == JOB_LEN_C) begin
                  state_q    <= WAIT;
                  cInValid_q <= 1'b0;
                  cDelay_q   <= '0;
                  cSource_q  <= '0;
                  cDest_q    <= '0;
                  wcnt_q     <= '0;
                  rcnt_q     <= '0;
`ifdef STA_TIMEOUT_EN
                  tcnt_q     <= '0;
`endif
               end else begin
                  cDelay_q  <= issueDelay;
                  cSource_q <= srcMem[issueIdx];
                  cDest_q   <= dstMem[issueIdx];
                  rcnt_q    <= rcnt_q + 1'b1;
               end
            end
            WAIT: begin
               if (bus.c_out_valid) begin
                  rWorst_q <= bus.c_worst_delay;
                  pcnt_q   <= PW'(1);
                  state_q  <= COLLECT;
               end
`ifdef STA_TIMEOUT_EN
               else if (tcnt_q == TIMEOUT_LAST_C) begin
                  rErr_q   <= 1'b1;
                  plen_q   <= PW'(1);
                  dcnt_q   <= '0;
                  rWorst_q <= '0;
                  rPath_q  <= '0;
                  rLast_q  <= 1'b1;
                  rValid_q <= 1'b1;
                  state_q  <= DRAIN;
               end else begin
                  tcnt_q <= tcnt_q + 1'b1;
               end
`endif
            end
            COLLECT: begin
               if (bus.c_out_valid) begin
                  if (pcnt_q < MAX_PATH_C)
                     pcnt_q <= pcnt_q + 1'b1;
               end else begin
                  plen_q   <= pcnt_q;
                  dcnt_q   <= '0;
                  rValid_q <= 1'b1;
                  rPath_q  <= pathMem[0];
                  rLast_q  <= (pcnt_q == PW'(1));
                  state_q  <= DRAIN;
               end
            end
            DRAIN: begin
               if (bus.r_ready) begin
                  if (rLast_q) begin
                     rValid_q <= 1'b0;
                     rLast_q  <= 1'b0;
                     rPath_q  <= '0;
                     state_q  <= IDLE;
                  end else begin
                     dcnt_q  <= dcnt_d;
                     rPath_q <= pathMem[dcnt_d[PAW-1:0]];
                     rLast_q <= (dcnt_d == plen_q - 1'b1);
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sta_job_ctrl.sv
// tb_sta_job_ctrl: scoreboard bench for sta_job_ctrl. Host beats push the
// expected core beats, the core model pushes the expected result beats, and
// each test task pops and compares them against what the DUT produced.
module tb_sta_job_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;

   int checkCount = 0;
   int passCount  = 0;

   logic [11:0] expCore[$];
   logic [11:0] gotCore[$];
   logic [13:0] expRes[$];
   logic [13:0] gotRes[$];

   int lastAcceptCyc, riseCyc, fallCyc, burstLen;
   int hStall, stallErr, stallSeen, lastHsCyc, firstValidCyc, coreFallCyc;
   int timeoutHits = 0;

   sta_job_ctrl_if bus();

   sta_job_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Free-running clock and cycle counter used for latency checks
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Hard stop in case something above is mis-bounded
   initial begin
      #800000;
      $display("[TB] FAIL watchdog: got no finish want finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Host driver: streams one 32-beat job and pushes the expected core beats
   task automatic applyStimulus(input int kind);
      logic [3:0] d, s, t;
      int w;
      for (int i = 0; i < 32; i++) begin
         if (kind == 0) begin
            d = (i < 15) ? 4'(i + 1) : ((i == 15) ? 4'd0 : 4'(i));
            s = 4'(i);
            t = 4'(i + 1);
         end else begin
            d = 4'($urandom);
            s = 4'($urandom);
            t = 4'($urandom);
         end
         bus.h_valid       = 1'b1;
         bus.h_delay       = d;
         bus.h_source      = s;
         bus.h_destination = t;
         expCore.push_back({((i < 16) ? d : 4'd0), s, t});
         w = 0;
         forever begin
            @(negedge clk);
            if (bus.h_ready === 1'b1) begin
               lastAcceptCyc = cyc;
               @(posedge clk); #1;
               break;
            end
            hStall++;
            w++;
            @(posedge clk); #1;
            if (w > 2000) begin
               timeoutHits++;
               bus.h_valid = 1'b0;
               return;
            end
         end
      end
      bus.h_valid = 1'b0;
   endtask

   // Records one c_in_valid burst into gotCore
   task automatic captureBurst();
      int w = 0;
      gotCore.delete();
      burstLen = 0;
      @(negedge clk);
      while (bus.c_in_valid !== 1'b1) begin
         w++;
         if (w > 3000) begin
            timeoutHits++;
            @(posedge clk); #1;
            return;
         end
         @(negedge clk);
      end
      riseCyc = cyc;
      while (bus.c_in_valid === 1'b1 && burstLen < 100) begin
         gotCore.push_back({bus.c_delay, bus.c_source, bus.c_destination});
         burstLen++;
         @(negedge clk);
      end
      fallCyc = cyc;
      @(posedge clk); #1;
   endtask

   // Core model: emits n result beats and pushes the expected drained beats
   task automatic coreRespond(input logic [7:0] worst, input int n, input int base);
      int m;
      repeat (3) begin @(posedge clk); #1; end
      for (int k = 0; k < n; k++) begin
         bus.c_out_valid   = 1'b1;
         bus.c_worst_delay = (k == 0) ? worst : ~worst;
         bus.c_path        = 4'(base + k);
         @(posedge clk); #1;
      end
      bus.c_out_valid   = 1'b0;
      bus.c_worst_delay = '0;
      bus.c_path        = '0;
      coreFallCyc = cyc;
      m = (n < 16) ? n : 16;
      for (int j = 0; j < m; j++)
         expRes.push_back({1'b0, (j == m - 1), worst, 4'(base + j)});
   endtask

   // Host result sink: mode 0 always ready, mode 1 toggles ready every cycle
   task automatic drainResults(input int mode);
      int k = 0;
      logic [13:0] held, cur;
      logic stalled = 1'b0;
      gotRes.delete();
      stallErr = 0;
      stallSeen = 0;
      firstValidCyc = -1;
      forever begin
         bus.r_ready = (mode == 0) ? 1'b1 : ((k % 2) == 1);
         @(negedge clk);
         cur = {bus.r_err, bus.r_last, bus.r_worst_delay, bus.r_path};
         if (stalled && (bus.r_valid !== 1'b1 || cur !== held))
            stallErr++;
         stalled = 1'b0;
         if (bus.r_valid === 1'b1) begin
            if (firstValidCyc < 0)
               firstValidCyc = cyc;
            if (bus.r_ready) begin
               gotRes.push_back(cur);
               if (bus.r_last === 1'b1) begin
                  lastHsCyc = cyc;
                  @(posedge clk); #1;
                  bus.r_ready = 1'b0;
                  return;
               end
            end else begin
               stalled = 1'b1;
               held = cur;
               stallSeen++;
            end
         end
         k++;
         if (k > 3000 || gotRes.size() > 40) begin
            timeoutHits++;
            @(posedge clk); #1;
            bus.r_ready = 1'b0;
            return;
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      @(negedge clk);
      checkCount++;
      if (bus.h_ready !== 1'b0) $display("[TB] FAIL reset_h_ready: got %b want 0", bus.h_ready);
      else passCount++;
      checkCount++;
      if ({bus.c_in_valid, bus.r_valid, bus.busy, bus.r_err, bus.r_last} !== 5'b0)
         $display("[TB] FAIL reset_flags: got %b want 00000",
                  {bus.c_in_valid, bus.r_valid, bus.busy, bus.r_err, bus.r_last});
      else passCount++;
      checkCount++;
      if ({bus.c_delay, bus.c_source, bus.c_destination, bus.r_worst_delay, bus.r_path} !== 24'h0)
         $display("[TB] FAIL reset_data: got %h want 0",
                  {bus.c_delay, bus.c_source, bus.c_destination, bus.r_worst_delay, bus.r_path});
      else passCount++;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      checkCount++;
      if (bus.h_ready !== 1'b1) $display("[TB] FAIL release_h_ready: got %b want 1", bus.h_ready);
      else passCount++;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      logic [11:0] e;
      logic [13:0] r;
      applyStimulus(0);
      captureBurst();
      checkCount++;
      if (riseCyc !== lastAcceptCyc + 2)
         $display("[TB] FAIL basic_issue_latency: got %0d want %0d", riseCyc - lastAcceptCyc, 2);
      else passCount++;
      checkCount++;
      if (burstLen !== 32) $display("[TB] FAIL basic_burst_len: got %0d want 32", burstLen);
      else passCount++;
      for (int i = 0; i < burstLen && expCore.size() > 0; i++) begin
         e = expCore.pop_front();
         checkCount++;
         if (gotCore[i] !== e) $display("[TB] FAIL basic_core_beat[%0d]: got %h want %h", i, gotCore[i], e);
         else passCount++;
      end
      expCore.delete();
      coreRespond(8'd45, 4, 0);
      drainResults(0);
      checkCount++;
      if (firstValidCyc !== coreFallCyc + 1)
         $display("[TB] FAIL basic_rvalid_latency: got %0d want %0d", firstValidCyc - coreFallCyc, 1);
      else passCount++;
      checkCount++;
      if (gotRes.size() !== 4) $display("[TB] FAIL basic_res_count: got %0d want 4", gotRes.size());
      else passCount++;
      for (int i = 0; i < gotRes.size() && expRes.size() > 0; i++) begin
         r = expRes.pop_front();
         checkCount++;
         if (gotRes[i] !== r) $display("[TB] FAIL basic_res_beat[%0d]: got %h want %h", i, gotRes[i], r);
         else passCount++;
      end
      expRes.delete();
      @(negedge clk);
      checkCount++;
      if (bus.busy !== 1'b0) $display("[TB] FAIL basic_idle_after: got %b want 0", bus.busy);
      else passCount++;
      @(posedge clk); #1;
      checkCount++;
      if (timeoutHits !== 0) $display("[TB] FAIL basic_no_hang: got %0d want 0", timeoutHits);
      else passCount++;
      timeoutHits = 0;
   endtask

   task automatic test_backpressure();
      logic [11:0] e;
      logic [13:0] r;
      applyStimulus(1);
      captureBurst();
      for (int i = 0; i < burstLen && expCore.size() > 0; i++) begin
         e = expCore.pop_front();
         checkCount++;
         if (gotCore[i] !== e) $display("[TB] FAIL bp_core_beat[%0d]: got %h want %h", i, gotCore[i], e);
         else passCount++;
      end
      expCore.delete();
      coreRespond(8'($urandom_range(1, 254)), 7, 4);
      drainResults(1);
      checkCount++;
      if (gotRes.size() !== 7) $display("[TB] FAIL bp_res_count: got %0d want 7", gotRes.size());
      else passCount++;
      for (int i = 0; i < gotRes.size() && expRes.size() > 0; i++) begin
         r = expRes.pop_front();
         checkCount++;
         if (gotRes[i] !== r) $display("[TB] FAIL bp_res_beat[%0d]: got %h want %h", i, gotRes[i], r);
         else passCount++;
      end
      expRes.delete();
      checkCount++;
      if (stallErr !== 0) $display("[TB] FAIL bp_hold_while_stalled: got %0d changes want 0", stallErr);
      else passCount++;
      checkCount++;
      if (stallSeen < 3) $display("[TB] FAIL bp_stalls_seen: got %0d want at least 3", stallSeen);
      else passCount++;
      checkCount++;
      if (timeoutHits !== 0) $display("[TB] FAIL bp_no_hang: got %0d want 0", timeoutHits);
      else passCount++;
      timeoutHits = 0;
   endtask

   task automatic test_overlap();
      logic [11:0] e;
      logic [13:0] r;
      applyStimulus(0);
      captureBurst();
      for (int i = 0; i < burstLen && expCore.size() > 0; i++) begin
         e = expCore.pop_front();
         checkCount++;
         if (gotCore[i] !== e) $display("[TB] FAIL ovl_core1_beat[%0d]: got %h want %h", i, gotCore[i], e);
         else passCount++;
      end
      expCore.delete();
      hStall = 0;
      applyStimulus(1);
      checkCount++;
      if (hStall !== 0) $display("[TB] FAIL ovl_refill_stalls: got %0d want 0", hStall);
      else passCount++;
      @(negedge clk);
      checkCount++;
      if ({bus.h_ready, bus.busy, bus.c_in_valid} !== 3'b010)
         $display("[TB] FAIL ovl_full_waiting: got %b want 010", {bus.h_ready, bus.busy, bus.c_in_valid});
      else passCount++;
      @(posedge clk); #1;
      coreRespond(8'd9, 3, 5);
      drainResults(0);
      for (int i = 0; i < gotRes.size() && expRes.size() > 0; i++) begin
         r = expRes.pop_front();
         checkCount++;
         if (gotRes[i] !== r) $display("[TB] FAIL ovl_res1_beat[%0d]: got %h want %h", i, gotRes[i], r);
         else passCount++;
      end
      expRes.delete();
      captureBurst();
      checkCount++;
      if (riseCyc !== lastHsCyc + 2)
         $display("[TB] FAIL ovl_second_issue: got %0d want %0d", riseCyc - lastHsCyc, 2);
      else passCount++;
      checkCount++;
      if (burstLen !== 32) $display("[TB] FAIL ovl_burst2_len: got %0d want 32", burstLen);
      else passCount++;
      for (int i = 0; i < burstLen && expCore.size() > 0; i++) begin
         e = expCore.pop_front();
         checkCount++;
         if (gotCore[i] !== e) $display("[TB] FAIL ovl_core2_beat[%0d]: got %h want %h", i, gotCore[i], e);
         else passCount++;
      end
      expCore.delete();
      coreRespond(8'd3, 2, 1);
      drainResults(0);
      for (int i = 0; i < gotRes.size() && expRes.size() > 0; i++) begin
         r = expRes.pop_front();
         checkCount++;
         if (gotRes[i] !== r) $display("[TB] FAIL ovl_res2_beat[%0d]: got %h want %h", i, gotRes[i], r);
         else passCount++;
      end
      expRes.delete();
      checkCount++;
      if (timeoutHits !== 0) $display("[TB] FAIL ovl_no_hang: got %0d want 0", timeoutHits);
      else passCount++;
      timeoutHits = 0;
   endtask

   task automatic test_overflow();
      logic [13:0] r;
      applyStimulus(1);
      captureBurst();
      expCore.delete();
      coreRespond(8'd200, 20, 0);
      drainResults(0);
      checkCount++;
      if (gotRes.size() !== 16) $display("[TB] FAIL ovf_res_count: got %0d want 16", gotRes.size());
      else passCount++;
      for (int i = 0; i < gotRes.size() && expRes.size() > 0; i++) begin
         r = expRes.pop_front();
         checkCount++;
         if (gotRes[i] !== r) $display("[TB] FAIL ovf_res_beat[%0d]: got %h want %h", i, gotRes[i], r);
         else passCount++;
      end
      expRes.delete();
      checkCount++;
      if (timeoutHits !== 0) $display("[TB] FAIL ovf_no_hang: got %0d want 0", timeoutHits);
      else passCount++;
      timeoutHits = 0;
   endtask

   task automatic test_reset_mid_issue();
      logic [11:0] e;
      logic [13:0] r;
      int w = 0;
      int beats = 0;
      applyStimulus(0);
      expCore.delete();
      @(negedge clk);
      while (bus.c_in_valid !== 1'b1 && w < 100) begin
         w++;
         @(negedge clk);
      end
      while (bus.c_in_valid === 1'b1 && beats < 10) begin
         beats++;
         @(negedge clk);
      end
      checkCount++;
      if (beats !== 10) $display("[TB] FAIL rst_reached_beat10: got %0d want 10", beats);
      else passCount++;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      checkCount++;
      if ({bus.c_in_valid, bus.busy, bus.h_ready} !== 3'b001)
         $display("[TB] FAIL rst_mid_issue_state: got %b want 001", {bus.c_in_valid, bus.busy, bus.h_ready});
      else passCount++;
      @(posedge clk); #1;
      applyStimulus(0);
      captureBurst();
      checkCount++;
      if (burstLen !== 32) $display("[TB] FAIL rst_burst_len: got %0d want 32", burstLen);
      else passCount++;
      for (int i = 0; i < burstLen && expCore.size() > 0; i++) begin
         e = expCore.pop_front();
         checkCount++;
         if (gotCore[i] !== e) $display("[TB] FAIL rst_core_beat[%0d]: got %h want %h", i, gotCore[i], e);
         else passCount++;
      end
      expCore.delete();
      coreRespond(8'd45, 4, 0);
      drainResults(0);
      for (int i = 0; i < gotRes.size() && expRes.size() > 0; i++) begin
         r = expRes.pop_front();
         checkCount++;
         if (gotRes[i] !== r) $display("[TB] FAIL rst_res_beat[%0d]: got %h want %h", i, gotRes[i], r);
         else passCount++;
      end
      expRes.delete();
      checkCount++;
      if (timeoutHits !== 0) $display("[TB] FAIL rst_no_hang: got %0d want 0", timeoutHits);
      else passCount++;
      timeoutHits = 0;
   endtask

`ifdef STA_TIMEOUT_EN
   task automatic test_timeout();
      logic [13:0] r;
      applyStimulus(1);
      captureBurst();
      expCore.delete();
      drainResults(0);
      checkCount++;
      if (firstValidCyc !== fallCyc + 1023)
         $display("[TB] FAIL to_latency: got %0d want %0d", firstValidCyc - fallCyc, 1023);
      else passCount++;
      checkCount++;
      if (gotRes.size() !== 1) $display("[TB] FAIL to_res_count: got %0d want 1", gotRes.size());
      else passCount++;
      r = {1'b1, 1'b1, 8'h00, 4'h0};
      checkCount++;
      if (gotRes.size() > 0 && gotRes[0] !== r) $display("[TB] FAIL to_res_beat: got %h want %h", gotRes[0], r);
      else passCount++;
      coreRespond(8'd5, 3, 2);
      expRes.delete();
      @(negedge clk);
      checkCount++;
      if ({bus.r_err, bus.busy, bus.r_valid} !== 3'b100)
         $display("[TB] FAIL to_sticky_late_ignored: got %b want 100", {bus.r_err, bus.busy, bus.r_valid});
      else passCount++;
      @(posedge clk); #1;
      applyStimulus(0);
      captureBurst();
      expCore.delete();
      @(negedge clk);
      checkCount++;
      if (bus.r_err !== 1'b0) $display("[TB] FAIL to_err_cleared: got %b want 0", bus.r_err);
      else passCount++;
      @(posedge clk); #1;
      coreRespond(8'd45, 4, 0);
      drainResults(0);
      for (int i = 0; i < gotRes.size() && expRes.size() > 0; i++) begin
         r = expRes.pop_front();
         checkCount++;
         if (gotRes[i] !== r) $display("[TB] FAIL to_res2_beat[%0d]: got %h want %h", i, gotRes[i], r);
         else passCount++;
      end
      expRes.delete();
      checkCount++;
      if (timeoutHits !== 0) $display("[TB] FAIL to_no_hang: got %0d want 0", timeoutHits);
      else passCount++;
      timeoutHits = 0;
   endtask
`endif

   // Test sequence
   initial begin
      bus.h_valid       = 1'b0;
      bus.h_delay       = '0;
      bus.h_source      = '0;
      bus.h_destination = '0;
      bus.c_out_valid   = 1'b0;
      bus.c_worst_delay = '0;
      bus.c_path        = '0;
      bus.r_ready       = 1'b0;
      test_reset();
      test_basic();
      test_backpressure();
      test_overlap();
      test_overflow();
      test_reset_mid_issue();
`ifdef STA_TIMEOUT_EN
      test_timeout();
`endif
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end
endmodule
